// File: rtl/p_mul_pkg.sv
// Shared types and constants for the p_mul sharing arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package p_mul_pkg;

    // One-hot pack widths understood by p_mul
    localparam logic [4:0] PW_32 = 5'b00001;
    localparam logic [4:0] PW_16 = 5'b00010;
    localparam logic [4:0] PW_8  = 5'b00100;
    localparam logic [4:0] PW_4  = 5'b01000;
    localparam logic [4:0] PW_2  = 5'b10000;

    // Width of the captured operation: 3 op selects + 5 pack width + 2x32 operands
    localparam int HOLD_W = 72;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Operation as presented to p_mul, captured once at grant time
    typedef struct packed {
        logic        mul_l;
        logic        mul_h;
        logic        clmul;
        logic [4:0]  pw;
        logic [31:0] crs1;
        logic [31:0] crs2;
    } hold_t;

endpackage

// File: rtl/p_mul_arb_pick.sv
// Rotating-start priority picker: first set request at or after start_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; any_o low when no request is set.
module p_mul_arb_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   start_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    int   pos;
    logic found;

    // Walk the requesters in priority order starting at start_i; first hit wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < NREQ; i++) begin
            pos = int'(start_i) + i;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            for (int j = 0; j < NREQ; j++) begin
                if (!found && (pos == j) && req_i[j]) begin
                    found    = 1'b1;
                    gnt_o[j] = 1'b1;
                    idx_o    = IW'(j);
                end
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/p_mul_arbiter.sv
// Shares one multi-cycle p_mul between NREQ requesters; P_MUL_ARB_RR_EN selects rotating priority.
// Latency: grant edge -> mul_valid next cycle; req_ready same cycle as mul_ready; one IDLE bubble after.
// Backpressure: requesters hold req_valid until their req_ready pulse; p_mul paces completion via mul_ready.
module p_mul_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ-1:0]      req_mul_l,
    input  logic [NREQ-1:0]      req_mul_h,
    input  logic [NREQ-1:0]      req_clmul,
    input  logic [5*NREQ-1:0]    req_pw,
    input  logic [32*NREQ-1:0]   req_crs1,
    input  logic [32*NREQ-1:0]   req_crs2,
    output logic [31:0]          req_result,
    output logic                 mul_valid,
    input  logic                 mul_ready,
    output logic                 mul_l,
    output logic                 mul_h,
    output logic                 mul_clmul,
    output logic [4:0]           mul_pw,
    output logic [31:0]          mul_crs1,
    output logic [31:0]          mul_crs2,
    input  logic [31:0]          mul_result,
    output logic [IW-1:0]        grant_idx,
    output logic                 busy
);

    import p_mul_pkg::*;

    state_t          state_q, state_d;
    hold_t           hold_q, hold_d;
    hold_t           cand;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   start_ptr;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            done;

`ifdef P_MUL_ARB_RR_EN
    logic [IW-1:0] prio_q, prio_d;

    assign start_ptr = prio_q;

    // Priority moves to the requester just after the one granted, wrapping at NREQ
    always_comb begin
        prio_d = prio_q;
        if (state_q == IDLE && pick_any) begin
            prio_d = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + IW'(1);
        end
    end

    // Priority pointer register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prio_q <= '0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    // Fixed priority: lowest index always wins
    assign start_ptr = '0;
`endif

    p_mul_arb_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i   (req_valid),
        .start_i (start_ptr),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // One-hot select of the winning requester's operation fields
    always_comb begin
        cand = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                cand.mul_l = req_mul_l[i];
                cand.mul_h = req_mul_h[i];
                cand.clmul = req_clmul[i];
                cand.pw    = req_pw[5*i +: 5];
                cand.crs1  = req_crs1[32*i +: 32];
                cand.crs2  = req_crs2[32*i +: 32];
            end
        end
    end

    // FSM next state: capture the winner once in IDLE, wait for p_mul in BUSY
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = BUSY;
                    hold_d  = cand;
                    grant_d = pick_idx;
                end
            end
            BUSY: begin
                if (mul_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, hold and owner registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
        end
    end

    assign busy      = (state_q == BUSY);
    assign mul_valid = busy;
    assign done      = busy && mul_ready;
    assign grant_idx = grant_q;

    // p_mul only ever sees the captured copy, never live requester ports
    assign mul_l     = hold_q.mul_l;
    assign mul_h     = hold_q.mul_h;
    assign mul_clmul = hold_q.clmul;
    assign mul_pw    = hold_q.pw;
    assign mul_crs1  = hold_q.crs1;
    assign mul_crs2  = hold_q.crs2;

    // Route completion and result to the owner only in the completion cycle
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = done && (grant_q == IW'(i));
        end
        req_result = done ? mul_result : 32'd0;
    end

endmodule

// File: tb/tb_p_mul_arbiter.sv
module tb_p_mul_arbiter;
    import p_mul_pkg::*;

    localparam int NREQ = 2;
    localparam int IW   = $clog2(NREQ);
    localparam int SOAK = 10000;

    logic                clock;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ-1:0]     req_mul_l, req_mul_h, req_clmul;
    logic [5*NREQ-1:0]   req_pw;
    logic [32*NREQ-1:0]  req_crs1, req_crs2;
    logic [31:0]         req_result;
    logic                mul_valid, mul_ready;
    logic                mul_l, mul_h, mul_clmul;
    logic [4:0]          mul_pw;
    logic [31:0]         mul_crs1, mul_crs2, mul_result;
    logic [IW-1:0]       grant_idx;
    logic                busy;

    int n_cmp  = 0;
    int n_fail = 0;

    p_mul_arbiter #(.NREQ(NREQ)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mul_l(req_mul_l), .req_mul_h(req_mul_h), .req_clmul(req_clmul),
        .req_pw(req_pw), .req_crs1(req_crs1), .req_crs2(req_crs2),
        .req_result(req_result),
        .mul_valid(mul_valid), .mul_ready(mul_ready),
        .mul_l(mul_l), .mul_h(mul_h), .mul_clmul(mul_clmul), .mul_pw(mul_pw),
        .mul_crs1(mul_crs1), .mul_crs2(mul_crs2), .mul_result(mul_result),
        .grant_idx(grant_idx), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 32-bit product slice: high half when h, else low half
    function automatic logic [31:0] exp_res(input logic h, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = 64'(a) * 64'(b);
        return h ? p[63:32] : p[31:0];
    endfunction

    // Stub p_mul: ready in the (k+1)th cycle of valid, i.e. latency k
    int   stub_cnt;
    int   k_cur = 3;
    logic force_rdy = 1'b0;
    always @(posedge clock or posedge reset) begin
        if (reset) stub_cnt <= 0;
        else if (mul_valid && !mul_ready) stub_cnt <= stub_cnt + 1;
        else stub_cnt <= 0;
    end
    assign mul_ready  = (mul_valid && (stub_cnt == k_cur)) | force_rdy;
    assign mul_result = exp_res(mul_h, mul_crs1, mul_crs2);

    task automatic set_port(input int p, input logic v, input logic h, input logic [31:0] a, input logic [31:0] b);
        req_valid[p] = v;
        req_mul_l[p] = !h;
        req_mul_h[p] = h;
        req_clmul[p] = 1'b0;
        req_pw[p*5 +: 5]    = PW_32;
        req_crs1[p*32 +: 32] = a;
        req_crs2[p*32 +: 32] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        force_rdy = 1'b0;
        req_valid = '0; req_mul_l = '0; req_mul_h = '0; req_clmul = '0;
        req_pw = '0; req_crs1 = '0; req_crs2 = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = '0; req_mul_l = '0; req_mul_h = '0; req_clmul = '0;
        req_pw = '0; req_crs1 = '0; req_crs2 = '0;
        @(negedge clock);
        n_cmp++; if (mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mul_valid got=%b want=0", mul_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b want=00", req_ready); end
        n_cmp++; if (req_result !== 32'd0) begin n_fail++; $display("FAIL reset_req_result got=%h want=0", req_result); end
        n_cmp++; if (grant_idx !== '0) begin n_fail++; $display("FAIL reset_grant_idx got=%0d want=0", grant_idx); end
        n_cmp++; if ({mul_crs1, mul_crs2, mul_pw, mul_l, mul_h, mul_clmul} !== 72'd0) begin
            n_fail++; $display("FAIL reset_hold got=%h/%h/%b want=0", mul_crs1, mul_crs2, mul_pw); end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (busy !== 1'b0 || mul_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle busy=%b mul_valid=%b want=0", busy, mul_valid); end
    endtask

    task automatic test_single();
        int lat;
        logic seen;
        do_reset();
        k_cur = 3;
        set_port(0, 1'b1, 1'b0, 32'd3, 32'd5);
        lat = 1; seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            lat++;
            if (lat == 2) begin
                n_cmp++; if (mul_valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_valid_n1 mul_valid=%b busy=%b want=1", mul_valid, busy); end
                n_cmp++; if (mul_crs1 !== 32'd3 || mul_crs2 !== 32'd5) begin n_fail++; $display("FAIL single_operands got=%0d,%0d want=3,5", mul_crs1, mul_crs2); end
            end
            if (req_ready != '0) begin seen = 1'b1; break; end
        end
        n_cmp++; if (!seen || lat != 5) begin n_fail++; $display("FAIL single_latency got=%0d seen=%b want=5", lat, seen); end
        n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_req_ready got=%b want=01", req_ready); end
        n_cmp++; if (req_result !== 32'd15) begin n_fail++; $display("FAIL single_result got=%0d want=15", req_result); end
        set_port(0, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clock);
        n_cmp++; if (req_ready !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL single_after req_ready=%b busy=%b want=00,0", req_ready, busy); end
        n_cmp++; if (req_result !== 32'd0) begin n_fail++; $display("FAIL single_result_idle got=%h want=0", req_result); end
    endtask

    task automatic test_round_robin();
        int n, e;
        logic [31:0] want;
        do_reset();
        k_cur = 2;
        set_port(0, 1'b1, 1'b0, 32'd7, 32'd9);
        set_port(1, 1'b1, 1'b1, 32'h1234_5678, 32'h9abc_def0);
        n = 0;
        for (int c = 0; c < 200 && n < 4; c++) begin
            @(negedge clock);
            if (req_ready != '0) begin
`ifdef P_MUL_ARB_RR_EN
                e = n % 2;
`else
                e = 0;
`endif
                want = (e == 0) ? exp_res(1'b0, 32'd7, 32'd9) : exp_res(1'b1, 32'h1234_5678, 32'h9abc_def0);
                n_cmp++; if (req_ready !== (2'b01 << e)) begin n_fail++; $display("FAIL rr_grant op=%0d got=%b want=%b", n, req_ready, 2'b01 << e); end
                n_cmp++; if (req_result !== want) begin n_fail++; $display("FAIL rr_result op=%0d got=%h want=%h", n, req_result, want); end
                n++;
                @(negedge clock);
                n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rr_bubble op=%0d busy=%b want=0", n, busy); end
            end
        end
        n_cmp++; if (n != 4) begin n_fail++; $display("FAIL rr_timeout completions=%0d want=4", n); end
        req_valid = '0;
    endtask

    task automatic test_operand_stability();
        logic seen;
        do_reset();
        k_cur = 3;
        set_port(0, 1'b1, 1'b0, 32'd3, 32'd5);
        @(negedge clock);
        req_crs1[31:0] = 32'hFFFF_FFFF;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            n_cmp++; if (mul_crs1 !== 32'd3) begin n_fail++; $display("FAIL stab_mul_crs1 got=%h want=3", mul_crs1); end
            if (req_ready != '0) begin
                seen = 1'b1;
                n_cmp++; if (req_result !== 32'd15) begin n_fail++; $display("FAIL stab_result got=%0d want=15", req_result); end
                break;
            end
            @(negedge clock);
        end
        n_cmp++; if (!seen) begin n_fail++; $display("FAIL stab_timeout seen=%b want=1", seen); end
        req_valid = '0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        k_cur = 5;
        set_port(0, 1'b1, 1'b0, 32'd11, 32'd13);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_cmp++; if (mul_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_async mul_valid=%b busy=%b want=0", mul_valid, busy); end
        n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL midrst_ready got=%b want=00", req_ready); end
        set_port(1, 1'b1, 1'b0, 32'd2, 32'd4);
        @(negedge clock);
        n_cmp++; if (req_ready !== 2'b00 || busy !== 1'b0) begin n_fail++; $display("FAIL midrst_held ready=%b busy=%b want=00,0", req_ready, busy); end
        reset = 1'b0;
        @(negedge clock);
        n_cmp++; if (busy !== 1'b1 || grant_idx !== '0) begin n_fail++; $display("FAIL midrst_prio busy=%b grant=%0d want=1,0", busy, grant_idx); end
        n_cmp++; if (mul_crs1 !== 32'd11) begin n_fail++; $display("FAIL midrst_recapture got=%0d want=11", mul_crs1); end
        req_valid = '0;
    endtask

    task automatic test_spurious_ready();
        do_reset();
        @(negedge clock);
        force_rdy = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b00 || req_result !== 32'd0) begin n_fail++; $display("FAIL spur_ready ready=%b result=%h want=00,0", req_ready, req_result); end
        @(negedge clock);
        force_rdy = 1'b0;
        n_cmp++; if (busy !== 1'b0 || mul_valid !== 1'b0) begin n_fail++; $display("FAIL spur_state busy=%b mul_valid=%b want=0", busy, mul_valid); end
    endtask

    task automatic test_soak();
        logic        m_busy;
        int          m_owner, m_cyc, m_k, m_prio, w;
        logic [31:0] m_exp;
        logic [1:0]  exp_rdy;
        logic        drained;
        int          issued[NREQ];
        int          seen_cnt[NREQ];
        do_reset();
        m_busy = 1'b0; m_owner = 0; m_cyc = 0; m_k = 0; m_prio = 0; m_exp = '0;
        drained = 1'b0;
        for (int p = 0; p < NREQ; p++) begin issued[p] = 0; seen_cnt[p] = 0; end
        k_cur = $urandom_range(1, 8);
        for (int cyc = 0; cyc < SOAK + 400; cyc++) begin
            @(negedge clock);
            exp_rdy = (m_busy && m_cyc == m_k) ? (2'b01 << m_owner) : 2'b00;
            n_cmp++; if (busy !== m_busy || mul_valid !== m_busy) begin n_fail++; $display("FAIL soak_busy cyc=%0d busy=%b mul_valid=%b want=%b", cyc, busy, mul_valid, m_busy); end
            n_cmp++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL soak_ready cyc=%0d got=%b want=%b", cyc, req_ready, exp_rdy); end
            n_cmp++; if (req_result !== ((exp_rdy != 0) ? m_exp : 32'd0)) begin n_fail++; $display("FAIL soak_result cyc=%0d got=%h want=%h", cyc, req_result, (exp_rdy != 0) ? m_exp : 32'd0); end
            if (m_busy) begin
                n_cmp++; if (grant_idx !== IW'(m_owner)) begin n_fail++; $display("FAIL soak_grant cyc=%0d got=%0d want=%0d", cyc, grant_idx, m_owner); end
            end
            for (int p = 0; p < NREQ; p++) if (req_ready[p]) seen_cnt[p]++;
            // requester behaviour for the next edge
            if (m_busy && m_cyc == m_k) req_valid[m_owner] = 1'b0;
            else if (m_busy && $urandom_range(0, 2) == 0) begin
                req_crs1[m_owner*32 +: 32] = $urandom;
                req_crs2[m_owner*32 +: 32] = $urandom;
            end
            if (!m_busy) k_cur = $urandom_range(1, 8);
            for (int p = 0; p < NREQ; p++) begin
                if (!req_valid[p] && cyc < SOAK && $urandom_range(0, 2) == 0) begin
                    set_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
                    issued[p]++;
                end
            end
            // reference model advance over the coming edge
            if (m_busy) begin
                if (m_cyc == m_k) m_busy = 1'b0;
                else m_cyc++;
            end else if (req_valid != '0) begin
                w = -1;
                for (int i = 0; i < NREQ; i++) begin
`ifdef P_MUL_ARB_RR_EN
                    if (w < 0 && req_valid[(m_prio + i) % NREQ]) w = (m_prio + i) % NREQ;
`else
                    if (w < 0 && req_valid[i]) w = i;
`endif
                end
                m_owner = w;
                m_exp   = exp_res(req_mul_h[w], req_crs1[w*32 +: 32], req_crs2[w*32 +: 32]);
                m_k     = k_cur;
                m_cyc   = 0;
                m_busy  = 1'b1;
                m_prio  = (w + 1) % NREQ;
            end
            if (cyc >= SOAK && !m_busy && req_valid == '0) begin drained = 1'b1; break; end
        end
        n_cmp++; if (!drained) begin n_fail++; $display("FAIL soak_drain_timeout valid=%b busy=%b want=drained", req_valid, busy); end
        for (int p = 0; p < NREQ; p++) begin
            n_cmp++; if (seen_cnt[p] != issued[p]) begin n_fail++; $display("FAIL soak_once port=%0d completed=%0d issued=%0d", p, seen_cnt[p], issued[p]); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_operand_stability();
        test_reset_mid_op();
        test_spurious_ready();
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
